// File: rtl/alu_pipe.sv
// Handshaked ALU with a registered result/flag stage and iterative variable shifts.
// Define ALU_PIPE_MUL_EN to build the shift-add multiplier for op 1000 (otherwise it is illegal).
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             illegal
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef ALU_PIPE_MUL_EN
  localparam logic [1:0] ST_MUL   = 2'd2;
  localparam logic [3:0] OP_MUL   = 4'h8;
  localparam logic [SHW:0] MUL_STEPS = (SHW+1)'(WIDTH);
`endif
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SHL = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_EQ  = 4'h7;
  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

  logic [1:0]       state_q, state_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             left_q, left_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q;
  logic             carry_q, zero_q, negative_q, overflow_q, illegal_q;

  logic             accept;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] shifted;
  logic             shout;
  logic             ld_en;
  logic [WIDTH-1:0] ld_res;
  logic             ld_carry, ld_ovf, ld_ill;

  assign shamt    = b[SHW-1:0];
  assign sum      = {1'b0, a} + {1'b0, b};
  assign diff     = {1'b0, a} - {1'b0, b};
  assign shifted  = left_q ? {work_q[WIDTH-2:0], 1'b0} : {1'b0, work_q[WIDTH-1:1]};
  assign shout    = left_q ? work_q[WIDTH-1] : work_q[0];
  assign in_ready = rst_n && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH:0]     mul_sum;

  // Multiplier lives in the low half of the accumulator and is consumed LSB first.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign acc_step = {mul_sum, acc_q[WIDTH-1:1]};
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    left_d   = left_q;
    ld_en    = 1'b0;
    ld_res   = '0;
    ld_carry = 1'b0;
    ld_ovf   = 1'b0;
    ld_ill   = 1'b0;
`ifdef ALU_PIPE_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            OP_ADD: begin
              ld_en    = 1'b1;
              ld_res   = sum[WIDTH-1:0];
              ld_carry = sum[WIDTH];
              ld_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
              ld_en    = 1'b1;
              ld_res   = diff[WIDTH-1:0];
              ld_carry = diff[WIDTH];
              ld_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: begin ld_en = 1'b1; ld_res = a & b; end
            OP_OR:  begin ld_en = 1'b1; ld_res = a | b; end
            OP_XOR: begin ld_en = 1'b1; ld_res = a ^ b; end
            OP_EQ:  begin ld_en = 1'b1; ld_res = {{(WIDTH-1){1'b0}}, a == b}; end
            OP_SHL, OP_SHR: begin
              if (shamt == '0) begin
                ld_en  = 1'b1;
                ld_res = a;
              end else begin
                state_d = ST_SHIFT;
                work_d  = a;
                cnt_d   = {1'b0, shamt};
                left_d  = (op == OP_SHL);
              end
            end
`ifdef ALU_PIPE_MUL_EN
            OP_MUL: begin
              state_d = ST_MUL;
              acc_d   = {{WIDTH{1'b0}}, b};
              mcand_d = a;
              cnt_d   = MUL_STEPS;
            end
`endif
            default: begin ld_en = 1'b1; ld_ill = 1'b1; end
          endcase
        end
      end
      ST_SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          ld_en    = 1'b1;
          ld_res   = shifted;
          ld_carry = shout;
          state_d  = ST_IDLE;
        end
      end
`ifdef ALU_PIPE_MUL_EN
      ST_MUL: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          ld_en    = 1'b1;
          ld_res   = acc_step[WIDTH-1:0];
          ld_carry = |acc_step[2*WIDTH-1:WIDTH];
          state_d  = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // A load only ever happens into an empty or draining output stage, so it always wins.
  assign out_valid_d = ld_en || (out_valid_q && !out_ready);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset as well, so an aborted operation leaves nothing behind.
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      left_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      acc_q       <= '0;
      mcand_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      left_q      <= left_d;
      out_valid_q <= out_valid_d;
      if (ld_en) begin
        result_q   <= ld_res;
        carry_q    <= ld_carry;
        zero_q     <= (ld_res == '0);
        negative_q <= ld_res[WIDTH-1];
        overflow_q <= ld_ovf;
        illegal_q  <= ld_ill;
      end
`ifdef ALU_PIPE_MUL_EN
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;

endmodule
